// File: rtl/sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_if
//   Bundles every bus signal around the SRAM port arbiter: the instruction-fetch
//   requester, the load/store requester and the unified single-port SRAM.
//
//   Groups
//     inst_*  : req/addr in, gnt/rvalid/rdata out (fetch side, read only)
//     data_*  : req/we/addr/wdata in, gnt/rvalid/rdata out (load/store side)
//     sram_*  : en/we/addr/wdata out, rdata in (rdata valid the cycle after en)
//
//   Modports
//     slave   : the arbiter's view (consumes requests, drives grants and SRAM)
//     master  : the environment's view (requesters plus the SRAM itself)
// -----------------------------------------------------------------------------
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // fetch side
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;

  // load/store side
  logic              data_req;
  logic [BE_W-1:0]   data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  // SRAM side
  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_gnt, inst_rvalid, inst_rdata,
    input  data_req, data_we, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_gnt, inst_rvalid, inst_rdata,
    output data_req, data_we, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port SRAM (1-cycle read latency) between instruction
//   fetch and data load/store. Grants are combinational in the request cycle;
//   the response (rvalid/rdata) follows exactly one cycle after the grant.
//   Data wins by default; after STARVE_MAX consecutive data grants with a
//   fetch waiting, the fetch is forced through.
//
//   Ports
//     clk  : clock, all state on posedge
//     rst  : synchronous active-high reset; also gates grants/responses
//     bus  : sram_port_arbiter_if.slave (fetch, load/store and SRAM signals)
//
//   Parameters
//     ADDR_W, DATA_W : bus widths (byte enables are DATA_W/8 wide)
//     STARVE_MAX     : data grants tolerated while a fetch waits (>= 1)
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // Who owns the SRAM read port response in the current cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_INST = 2'd1,
    OWNER_DATA = 2'd2
  } owner_e;

  owner_e           resp_owner_q, resp_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic force_inst;
  logic inst_gnt;
  logic data_gnt;
  logic sram_en;
  logic inst_rvalid;
  logic data_rvalid;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are gated by rst so nothing reaches the SRAM while the
  // block is held in reset, even though the state clears only on the edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    force_inst = bus.inst_req & (starve_cnt_q == STARVE_LIM);
    inst_gnt   = ~rst & bus.inst_req & (~bus.data_req | force_inst);
    data_gnt   = ~rst & bus.data_req & ~inst_gnt;
  end

  assign sram_en = inst_gnt | data_gnt;

  // ---------------------------------------------------------------------------
  // SRAM drive: address from the granted side, write enables only for data.
  // Everything is forced to zero in idle cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.sram_addr = '0;
    if (inst_gnt) begin
      bus.sram_addr = bus.inst_addr;
    end else if (data_gnt) begin
      bus.sram_addr = bus.data_addr;
    end
  end

  assign bus.sram_en    = sram_en;
  assign bus.sram_we    = data_gnt ? bus.data_we : {BE_W{1'b0}};
  assign bus.sram_wdata = sram_en ? bus.data_wdata : {DATA_W{1'b0}};
  assign bus.inst_gnt   = inst_gnt;
  assign bus.data_gnt   = data_gnt;

  // ---------------------------------------------------------------------------
  // Starvation counter: counts data grants taken while a fetch is waiting.
  // A fetch grant or a withdrawn fetch request restarts the count. It stops at
  // STARVE_LIM, where force_inst guarantees the next cycle clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (inst_gnt || !bus.inst_req) begin
      starve_cnt_d = '0;
    end else if (data_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Response owner: the side granted this cycle owns next cycle's read data.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_owner_d = OWNER_NONE;
    if (inst_gnt) begin
      resp_owner_d = OWNER_INST;
    end else if (data_gnt) begin
      resp_owner_d = OWNER_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner_q <= OWNER_NONE;
      starve_cnt_q <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A response already in flight when rst rises is dropped by the rst gate.
  assign inst_rvalid = ~rst & (resp_owner_q == OWNER_INST);
  assign data_rvalid = ~rst & (resp_owner_q == OWNER_DATA);

  assign bus.inst_rvalid = inst_rvalid;
  assign bus.data_rvalid = data_rvalid;
  assign bus.inst_rdata  = inst_rvalid ? bus.sram_rdata : {DATA_W{1'b0}};
  assign bus.data_rdata  = data_rvalid ? bus.sram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed phases (reset, fetch stream, load vs fetch, partial store,
//   starvation, reset mid-operation) followed by randomized traffic. A
//   behavioural SRAM answers the DUT; a shadow memory plus a small arbitration
//   model predict every grant, SRAM drive value and response.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int STARVE_MAX = 4;
  localparam int MEM_WORDS  = 256;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [DATA_W-1:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- behavioural SRAM (read-before-write, 1-cycle latency) ---
  logic [DATA_W-1:0] sram_mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_WORDS; i++) sram_mem[i] <= init_word(i);
      bus.sram_rdata <= '0;
    end else if (bus.sram_en) begin
      bus.sram_rdata <= sram_mem[bus.sram_addr[9:2]];
      for (int b = 0; b < BE_W; b++)
        if (bus.sram_we[b]) sram_mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model state -----------------------------------
  logic [DATA_W-1:0] shadow [MEM_WORDS];
  int                streak     = 0;   // data grants taken while a fetch waited
  int                owner      = 0;   // 0 none, 1 fetch, 2 data
  logic [DATA_W-1:0] resp_data  = '0;
  bit                resp_write = 1'b0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational and response outputs at negedge, then
  // advance the model on the posedge. Returns the predicted grants.
  task automatic cycle(output bit gi, output bit gd);
    logic [ADDR_W-1:0] ea;
    logic [BE_W-1:0]   ewe;
    logic [DATA_W-1:0] ewd;
    bit                ireq, vi, vd;
    int                idx;
    @(negedge clk);
    ireq = bus.inst_req;
    gi = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      gi = bus.inst_req && (!bus.data_req || streak == STARVE_MAX);
      gd = bus.data_req && !gi;
    end
    ea  = gi ? bus.inst_addr : (gd ? bus.data_addr : '0);
    ewe = gd ? bus.data_we : '0;
    ewd = (gi || gd) ? bus.data_wdata : '0;
    vi  = !rst && owner == 1;
    vd  = !rst && owner == 2;
    check("inst_gnt",    bus.inst_gnt,    gi);
    check("data_gnt",    bus.data_gnt,    gd);
    check("sram_en",     bus.sram_en,     gi || gd);
    check("sram_addr",   bus.sram_addr,   ea);
    check("sram_we",     bus.sram_we,     ewe);
    check("sram_wdata",  bus.sram_wdata,  ewd);
    check("inst_rvalid", bus.inst_rvalid, vi);
    check("data_rvalid", bus.data_rvalid, vd);
    check("inst_rdata",  bus.inst_rdata,  vi ? resp_data : '0);
    if (!(vd && resp_write))
      check("data_rdata", bus.data_rdata, vd ? resp_data : '0);
    @(posedge clk);
    if (rst) begin
      streak = 0;
      owner  = 0;
    end else begin
      owner = gi ? 1 : (gd ? 2 : 0);
      if (gi || gd) begin
        idx        = int'(ea[9:2]);
        resp_data  = shadow[idx];
        resp_write = gd && (ewe != '0);
        for (int b = 0; b < BE_W; b++)
          if (ewe[b]) shadow[idx][8*b +: 8] = ewd[8*b +: 8];
      end
      if (gi || !ireq) streak = 0;
      else if (gd)     streak++;
    end
    #1;
  endtask

  task automatic drive_inst(bit req, logic [ADDR_W-1:0] addr);
    bus.inst_req  = req;
    bus.inst_addr = addr;
  endtask

  task automatic drive_data(bit req, logic [BE_W-1:0] we, logic [ADDR_W-1:0] addr,
                            logic [DATA_W-1:0] wdata);
    bus.data_req   = req;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
  endtask

  initial begin
    bit                gi, gd, ip, dp;
    logic [ADDR_W-1:0] ia, da;
    logic [DATA_W-1:0] w;

    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = init_word(i);
    mem_load = 1'b1;
    rst      = 1'b1;

    // 1: reset with both sides requesting, then fetch right after release
    ia = 32'h1c00_0000;
    drive_inst(1'b1, ia);
    drive_data(1'b1, 4'h0, 32'h0000_0100, 32'h1234_5678);
    cycle(gi, gd);
    cycle(gi, gd);
    mem_load = 1'b0;
    rst      = 1'b0;
    drive_data(1'b0, 4'h0, '0, '0);
    cycle(gi, gd);

    // 2: fetch stream, grant every cycle
    for (int k = 0; k < 8; k++) begin
      ia = ia + 32'd4;
      drive_inst(1'b1, ia);
      cycle(gi, gd);
    end

    // 3: load contends with fetch, data wins
    ia = ia + 32'd4;
    drive_inst(1'b1, ia);
    drive_data(1'b1, 4'h0, 32'h0000_0100, '0);
    cycle(gi, gd);
    check("t3_load_rvalid", bus.data_rvalid, 1'b1);
    check("t3_load_rdata",  bus.data_rdata,  init_word(64));
    drive_data(1'b0, 4'h0, '0, '0);
    cycle(gi, gd);

    // 4: partial store, then read it back merged
    drive_inst(1'b0, ia);
    drive_data(1'b1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF);
    cycle(gi, gd);
    check("t4_store_rvalid", bus.data_rvalid, 1'b1);
    drive_data(1'b1, 4'h0, 32'h0000_0200, '0);
    cycle(gi, gd);
    w = init_word(128);
    check("t4_merged_rdata", bus.data_rdata, {w[31:16], 16'hBEEF});
    drive_data(1'b0, 4'h0, '0, '0);
    cycle(gi, gd);

    // 5: both sides saturate -> D,D,D,D,I repeating
    da = 32'h0000_0300;
    drive_inst(1'b1, ia);
    drive_data(1'b1, 4'h0, da, '0);
    for (int n = 0; n < 15; n++) begin
      cycle(gi, gd);
      check("t5_pattern", gi, (n % 5) == 4);
      if (gi) begin ia = ia + 32'd4; drive_inst(1'b1, ia); end
      if (gd) begin da = da + 32'd4; drive_data(1'b1, 4'h0, da, '0); end
    end

    // 6: reset the cycle after a data grant, then starvation restarts at 0
    drive_inst(1'b0, ia);
    drive_data(1'b1, 4'h0, 32'h0000_0040, '0);
    cycle(gi, gd);
    rst = 1'b1;
    cycle(gi, gd);
    rst = 1'b0;
    drive_inst(1'b1, ia);
    for (int n = 0; n < 10; n++) begin
      cycle(gi, gd);
      check("t6_pattern", gi, (n % 5) == 4);
      if (gi) begin ia = ia + 32'd4; drive_inst(1'b1, ia); end
    end

    // 7: randomized traffic, requests held until granted
    ip = 1'b0;
    dp = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!ip) begin
        ip = ($urandom_range(0, 3) != 0);
        bus.inst_addr = 32'h1c00_0000 + (32'($urandom_range(0, 255)) << 2);
      end
      if (!dp) begin
        dp = ($urandom_range(0, 2) != 0);
        bus.data_addr  = 32'($urandom_range(0, 255)) << 2;
        bus.data_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        bus.data_wdata = $urandom;
      end
      bus.inst_req = ip;
      bus.data_req = dp;
      rst = ($urandom_range(0, 60) == 0);
      cycle(gi, gd);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
